debug_oci_arbiter: RTL and testbench
====================================

DEBUG_OCI_ARBITER -- requirements
Module: debug_oci_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, OCI address width.
REQ-002 Parameter DATA_W, default 32, OCI data width.
REQ-003 Parameter TIMEOUT, default 255, max cycles in WAIT before error completion; legal range 2..255.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester command valid; bit 0 = JTAG side, bit 1 = host side.
REQ-007 req_ready  out  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-008 req_write  in  2  per-requester 1 = write, 0 = read.
REQ-009 req_addr  in  2*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  2*DATA_W  requester i write data in slice [i*DATA_W +: DATA_W].
REQ-011 rsp_valid  out  2  one-cycle completion strobe to the granted requester.
REQ-012 rsp_err  out  1  completion ended by timeout; qualified by any rsp_valid bit.
REQ-013 rsp_rdata  out  DATA_W  read data; qualified by any rsp_valid bit.
REQ-014 oci_go  out  1  one-cycle command strobe to the OCI datapath.
REQ-015 oci_write, oci_addr, oci_wdata  out  1/ADDR_W/DATA_W  registered command; stable from oci_go until the next acceptance.
REQ-016 oci_done  in  1  one-cycle completion from the OCI datapath.
REQ-017 oci_rdata  in  DATA_W  read data, valid with oci_done.
REQ-018 busy  out  1  high whenever state != IDLE.
REQ-019 grant_id  out  1  index of requester owning the current or last transaction.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: req_ready SHALL be combinational; at most one bit set, only for a requester with req_valid high; never set outside IDLE.
REQ-022 Arbitration SHALL be round-robin: with both valid, the requester != last_grant wins; with one valid, it wins.
REQ-023 On acceptance in cycle T: command SHALL be registered, grant_id updated, state -> ISSUE at T+1.
REQ-024 ISSUE: oci_go SHALL be 1 for exactly one cycle (T+1); state -> WAIT; timer cleared to 0.
REQ-025 WAIT: oci_done high SHALL capture oci_rdata (forced to 0 for writes), clear err, and enter RESP next cycle.
REQ-026 WAIT without oci_done: timer SHALL increment; when timer == TIMEOUT-1, enter RESP with err=1 and rdata=0.
REQ-027 oci_done in the same cycle as timeout expiry SHALL count as normal completion (err=0).
REQ-028 RESP: rsp_valid[grant_id] SHALL be 1 for exactly one cycle with rsp_rdata/rsp_err; last_grant <= grant_id; state -> IDLE.
REQ-029 Minimum latency: accept T, oci_go T+1, oci_done T+2, rsp_valid T+3; next acceptance no earlier than T+4.
REQ-030 oci_done outside WAIT SHALL be ignored (no state, data or error change).
REQ-031 req_valid deasserted before acceptance SHALL leave no residual effect; no command is latched without a transfer.
REQ-032 rsp_rdata and rsp_err SHALL hold their value until the next RESP.

Reset
REQ-033 On reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, oci_go=0, oci_write=0, oci_addr=0, oci_wdata=0, busy=0, grant_id=0, timer=0, last_grant=1 (requester 0 wins the first tie).
REQ-034 Reset in any non-IDLE state SHALL abort the transaction with no rsp_valid.
REQ-035 An oci_done arriving after reset release SHALL be ignored per REQ-030.

Verification
REQ-036 Both valid from reset, read addr 0x010 (req0) and 0x020 (req1), oci_done 1 cycle after each oci_go, rdata 0xA5A5A5A5 then 0x5A5A5A5A -> req0 served first, rsp_valid=01 with 0xA5A5A5A5, then rsp_valid=10 with 0x5A5A5A5A, rsp_err=0 both.
REQ-037 Single write req1 addr 0x1FF wdata 0xDEADBEEF, oci_done at T+2 -> oci_go at T+1 with oci_write=1 and those values; rsp_valid=10 at T+3; rsp_rdata=0.
REQ-038 Read with oci_done never asserted, TIMEOUT=255 -> RESP entered 255 cycles after WAIT entry; rsp_err=1, rsp_rdata=0; next command accepted normally.
REQ-039 oci_done in the same cycle the timer reaches TIMEOUT-1, rdata 0x12345678 -> rsp_err=0, rsp_rdata=0x12345678.
REQ-040 Reset pulsed while in WAIT, then oci_done pulsed -> no rsp_valid, busy=0, oci_go stays 0, state IDLE.
REQ-041 req0 held valid continuously while req1 pulses valid once -> req1 granted on the next IDLE after req0's current transaction; stray oci_done in IDLE -> no effect.

Source files
------------

// File: rtl/debug_oci_arbiter_if.sv
// Bus bundle for the OCI arbiter.
// Carries the two-requester command/response side and the OCI datapath side.
interface debug_oci_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic                rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                oci_go;
    logic                oci_write;
    logic [ADDR_W-1:0]   oci_addr;
    logic [DATA_W-1:0]   oci_wdata;
    logic                oci_done;
    logic [DATA_W-1:0]   oci_rdata;
    logic                busy;
    logic                grant_id;

    // Arbiter view.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, oci_done, oci_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, oci_go, oci_write, oci_addr,
               oci_wdata, busy, grant_id
    );

    // Requester / OCI datapath view.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, oci_done, oci_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, oci_go, oci_write, oci_addr,
               oci_wdata, busy, grant_id
    );
endinterface

// File: rtl/debug_oci_arbiter.sv
// Two-requester (JTAG = 0, host = 1) round-robin arbiter in front of a single OCI
// datapath. One transaction in flight; a watchdog completes it with an error if the
// datapath never answers.
module debug_oci_arbiter #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    debug_oci_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic [7:0]        timer_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              oci_go_q;
    logic              oci_write_q;
    logic [ADDR_W-1:0] oci_addr_q;
    logic [DATA_W-1:0] oci_wdata_q;
    logic [1:0]        rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic       accept;
    logic       pick;
    logic [1:0] req_ready;

    // Round-robin pick and combinational accept, only offered while idle.
    always_comb begin
        accept    = 1'b0;
        pick      = 1'b0;
        req_ready = 2'b00;
        if (state_q == StIdle && !reset) begin
            // On a tie the requester that did not win last time goes first.
            pick   = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
            accept = |bus.req_valid;
            if (accept) req_ready[pick] = 1'b1;
        end
    end

    // Transaction FSM with registered command and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= 8'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            oci_go_q     <= 1'b0;
            oci_write_q  <= 1'b0;
            oci_addr_q   <= '0;
            oci_wdata_q  <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            oci_go_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StIssue;
                        oci_go_q    <= 1'b1;
                        grant_q     <= pick;
                        oci_write_q <= bus.req_write[pick];
                        oci_addr_q  <= pick ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                            : bus.req_addr[ADDR_W-1:0];
                        oci_wdata_q <= pick ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                            : bus.req_wdata[DATA_W-1:0];
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    timer_q <= 8'd0;
                end
                StWait: begin
                    // A completion on the expiry cycle still wins over the timeout.
                    if (bus.oci_done) begin
                        state_q     <= StResp;
                        rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= oci_write_q ? '0 : bus.oci_rdata;
                    end else if (timer_q == TimerLast) begin
                        state_q     <= StResp;
                        rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StResp: begin
                    last_grant_q <= grant_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.oci_go    = oci_go_q;
    assign bus.oci_write = oci_write_q;
    assign bus.oci_addr  = oci_addr_q;
    assign bus.oci_wdata = oci_wdata_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_debug_oci_arbiter.sv
// Randomized bench for debug_oci_arbiter against a transaction-level model:
// winner from the round-robin rule, completion cycle from the latency/timeout rule.
module tb_debug_oci_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 255;

    typedef logic [2*AW-1:0] addr2_t;
    typedef logic [2*DW-1:0] data2_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    debug_oci_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    debug_oci_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic        last_grant_m;
    logic [31:0] hold_rd;
    logic        hold_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w != 0) ? 2'b10 : 2'b01;
    endfunction

    // Random requester traffic while the arbiter is busy; none of it may be latched.
    task automatic scramble();
        bus.req_valid = 2'($urandom);
        bus.req_write = 2'($urandom);
        bus.req_addr  = addr2_t'($urandom);
        bus.req_wdata = {$urandom, $urandom};
    endtask

    task automatic idle_cycle(input bit stray);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.oci_done  = stray;
        bus.oci_rdata = $urandom;
        #1;
        check_eq("idle_busy", 64'(bus.busy), 64'(0));
        check_eq("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("idle_rdata_hold", 64'(bus.rsp_rdata), 64'(hold_rd));
        check_eq("idle_err_hold", 64'(bus.rsp_err), 64'(hold_err));
        check_eq("idle_go", 64'(bus.oci_go), 64'(0));
    endtask

    // dly: WAIT-cycle index on which oci_done is driven; negative means never.
    task automatic do_txn(input logic [1:0] vm, input logic [1:0] wr, input addr2_t addr,
                          input data2_t wd, input int dly, input logic [31:0] rd);
        int          w;
        int          k;
        bit          done_hit;
        logic [1:0]  oh;
        logic        ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        bus.req_valid = vm;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.oci_done  = 1'b0;
        #1;
        w  = (vm == 2'b11) ? (last_grant_m ? 0 : 1) : (vm[1] ? 1 : 0);
        oh = onehot(w);
        ew = wr[w];
        ea = addr[w*AW +: AW];
        ed = wd[w*DW +: DW];
        check_eq("accept_ready", 64'(bus.req_ready), 64'(oh));
        check_eq("accept_busy", 64'(bus.busy), 64'(0));
        check_eq("accept_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("accept_rdata_hold", 64'(bus.rsp_rdata), 64'(hold_rd));
        // Issue cycle.
        @(negedge clk);
        scramble();
        #1;
        check_eq("issue_go", 64'(bus.oci_go), 64'(1));
        check_eq("issue_write", 64'(bus.oci_write), 64'(ew));
        check_eq("issue_addr", 64'(bus.oci_addr), 64'(ea));
        check_eq("issue_wdata", 64'(bus.oci_wdata), 64'(ed));
        check_eq("issue_grant", 64'(bus.grant_id), 64'(w));
        check_eq("issue_ready", 64'(bus.req_ready), 64'(0));
        check_eq("issue_busy", 64'(bus.busy), 64'(1));
        // Wait cycles: done on index dly, otherwise timeout on index TO-1.
        k        = 0;
        done_hit = 1'b0;
        while (1) begin
            @(negedge clk);
            scramble();
            if (dly == k) begin
                bus.oci_done  = 1'b1;
                bus.oci_rdata = rd;
                done_hit      = 1'b1;
            end else begin
                bus.oci_done  = 1'b0;
                bus.oci_rdata = $urandom;
            end
            #1;
            check_eq("wait_go", 64'(bus.oci_go), 64'(0));
            check_eq("wait_busy", 64'(bus.busy), 64'(1));
            check_eq("wait_ready", 64'(bus.req_ready), 64'(0));
            check_eq("wait_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check_eq("wait_addr_stable", 64'(bus.oci_addr), 64'(ea));
            if (done_hit || k == int'(TO) - 1) break;
            k++;
        end
        // Response cycle; a stray done here must be ignored.
        @(negedge clk);
        scramble();
        bus.oci_done  = 1'($urandom);
        bus.oci_rdata = $urandom;
        #1;
        hold_err     = !done_hit;
        hold_rd      = (done_hit && !ew) ? rd : 32'h0;
        last_grant_m = w[0];
        check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
        check_eq("rsp_err", 64'(bus.rsp_err), 64'(hold_err));
        check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(hold_rd));
        check_eq("rsp_busy", 64'(bus.busy), 64'(1));
        check_eq("rsp_ready", 64'(bus.req_ready), 64'(0));
    endtask

    // Reset pulsed mid-WAIT, then a late oci_done.
    task automatic reset_in_wait();
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.oci_done  = 1'b0;
        @(negedge clk);                 // issue
        @(negedge clk);                 // wait, index 0
        bus.req_valid = 2'b00;
        reset         = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("rst_grant", 64'(bus.grant_id), 64'(0));
        check_eq("rst_addr", 64'(bus.oci_addr), 64'(0));
        bus.oci_done  = 1'b1;
        bus.oci_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.oci_done  = 1'b0;
        #1;
        check_eq("late_done_busy", 64'(bus.busy), 64'(0));
        check_eq("late_done_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("late_done_go", 64'(bus.oci_go), 64'(0));
        check_eq("late_done_rdata", 64'(bus.rsp_rdata), 64'(0));
        check_eq("late_done_err", 64'(bus.rsp_err), 64'(0));
        last_grant_m = 1'b1;
        hold_rd      = 32'h0;
        hold_err     = 1'b0;
    endtask

    initial begin
        int r;
        int dly;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.oci_done  = 1'b0;
        bus.oci_rdata = '0;
        last_grant_m  = 1'b1;
        hold_rd       = 32'h0;
        hold_err      = 1'b0;

        // Reset state, with requests pending that must not be offered a ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_ready", 64'(bus.req_ready), 64'(0));
        check_eq("reset_busy", 64'(bus.busy), 64'(0));
        check_eq("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
        check_eq("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check_eq("reset_go", 64'(bus.oci_go), 64'(0));
        check_eq("reset_cmd", {bus.oci_write, bus.oci_addr, bus.oci_wdata}, 64'(0));
        check_eq("reset_grant", 64'(bus.grant_id), 64'(0));
        bus.req_valid = 2'b00;
        reset         = 1'b0;

        // Tie from reset: req0 first, then req1.
        do_txn(2'b11, 2'b00, {9'h020, 9'h010}, '0, 0, 32'hA5A5_A5A5);
        do_txn(2'b11, 2'b00, {9'h020, 9'h010}, '0, 0, 32'h5A5A_5A5A);
        // Single write from req1, read data forced to zero.
        do_txn(2'b10, 2'b10, {9'h1FF, 9'h000}, {32'hDEAD_BEEF, 32'h0}, 0, 32'hCAFE_F00D);
        // Full timeout, then a normal command.
        do_txn(2'b01, 2'b00, {9'h000, 9'h033}, '0, -1, 32'h1111_1111);
        do_txn(2'b01, 2'b00, {9'h000, 9'h034}, '0, 1, 32'h2222_2222);
        // Done coincident with timer expiry.
        do_txn(2'b10, 2'b00, {9'h044, 9'h000}, '0, int'(TO) - 1, 32'h1234_5678);
        reset_in_wait();
        // req0 held, req1 joins once; stray done in idle.
        do_txn(2'b01, 2'b00, {9'h000, 9'h050}, '0, 2, 32'h0BAD_0001);
        idle_cycle(1'b1);
        do_txn(2'b11, 2'b00, {9'h061, 9'h060}, '0, 0, 32'h0BAD_0002);
        do_txn(2'b01, 2'b01, {9'h000, 9'h070}, {32'h0, 32'h7777_7777}, 3, 32'h0BAD_0003);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
            r = int'($urandom_range(0, 99));
            if (r < 3)      dly = -1;
            else if (r < 6) dly = int'(TO) - 1;
            else            dly = int'($urandom_range(0, 5));
            do_txn(2'($urandom_range(1, 3)), 2'($urandom), addr2_t'($urandom),
                   {$urandom, $urandom}, dly, $urandom);
        end
        idle_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
